// File: rtl/sfq_pkg.sv
// rtl/sfq_pkg.sv - shared defaults and phase type for the toggle-encoded pulse fan-out
package sfq_pkg;

  localparam int SFQ_DELAY_DEF = 5;
  localparam int SFQ_BEGIN_DEF = 8;
  localparam int SFQ_SEP_DEF   = 2;

  typedef enum logic {
    BLANK = 1'b0,
    RUN   = 1'b1
  } sfq_phase_t;

endpackage

// File: rtl/pulse_delay_line.sv
// rtl/pulse_delay_line.sv - DEPTH-stage single-bit shift register carrying pulses to emit time
module pulse_delay_line #(
  parameter int DEPTH = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] r_sr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sr <= '0;
    end else begin
      r_sr <= (r_sr << 1) | DEPTH'(din);
    end
  end

  assign dout = r_sr[DEPTH-1];

endmodule

// File: rtl/pulse_fanout_n.sv
// rtl/pulse_fanout_n.sv - toggle-encoded pulse fan-out with blanking, separation check,
// programmable latency, per-branch enable and emitted-pulse counter
module pulse_fanout_n
  import sfq_pkg::*;
#(
  parameter int N_OUT        = 2,
  parameter int DELAY        = SFQ_DELAY_DEF,
  parameter int BEGIN_CYCLES = SFQ_BEGIN_DEF,
  parameter int MIN_SEP      = SFQ_SEP_DEF,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in,
  input  logic [N_OUT-1:0] out_en,
  input  logic             viol_clr,
  output logic [N_OUT-1:0] out,
  output logic [CNT_W-1:0] pulse_count,
  output logic             viol
);

  localparam int CYC_W = $clog2(BEGIN_CYCLES + 1);
  localparam int SEP_W = $clog2(MIN_SEP + 1);

  sfq_phase_t       r_phase;
  logic [CYC_W-1:0] r_cyc;
  logic [SEP_W-1:0] r_sep;
  logic             r_in_q;
  logic [N_OUT-1:0] r_out;
  logic [CNT_W-1:0] r_count;
  logic             r_viol;

  logic w_pulse;
  logic w_sep_ok;
  logic w_accept;
  logic w_drop;
  logic w_emit;

  assign w_pulse  = in ^ r_in_q;
  assign w_sep_ok = (r_sep >= SEP_W'(MIN_SEP));
  assign w_accept = (r_phase == RUN) && w_pulse && w_sep_ok;
  assign w_drop   = (r_phase == RUN) && w_pulse && !w_sep_ok;

  pulse_delay_line #(
    .DEPTH(DELAY)
  ) u_delay (
    .clk  (clk),
    .rst  (rst),
    .din  (w_accept),
    .dout (w_emit)
  );

  // A dropped pulse does not re-arm the separation window; it ages like an idle cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_phase <= BLANK;
      r_cyc   <= '0;
      r_sep   <= SEP_W'(MIN_SEP);
      r_in_q  <= 1'b0;
      r_out   <= '0;
      r_count <= '0;
      r_viol  <= 1'b0;
    end else begin
      r_in_q <= in;

      case (r_phase)
        BLANK: begin
          r_cyc <= r_cyc + 1'b1;
          if (r_cyc == CYC_W'(BEGIN_CYCLES - 1)) begin
            r_phase <= RUN;
          end
        end
        RUN: begin
          r_phase <= RUN;
        end
        default: r_phase <= BLANK;
      endcase

      if (w_accept) begin
        r_sep <= SEP_W'(1);
      end else if (!w_sep_ok) begin
        r_sep <= r_sep + 1'b1;
      end

      if (w_drop) begin
        r_viol <= 1'b1;
      end else if (viol_clr) begin
        r_viol <= 1'b0;
      end

      if (w_emit) begin
        r_out   <= r_out ^ out_en;
        r_count <= r_count + 1'b1;
      end
    end
  end

  assign out         = r_out;
  assign pulse_count = r_count;
  assign viol        = r_viol;

endmodule

// File: tb/tb_pulse_fanout_n.sv
// tb/tb_pulse_fanout_n.sv - self-checking bench for pulse_fanout_n against a timeline model
module tb_pulse_fanout_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst      = 1'b1;
  logic       in_s     = 1'b0;
  logic       viol_clr = 1'b0;
  logic [3:0] out_en0  = 4'b1011;
  logic [0:0] out_en1  = 1'b1;

  logic [3:0] out0;
  logic [1:0] cnt0;
  logic       viol0;
  logic [0:0] out1;
  logic [7:0] cnt1;
  logic       viol1;

  pulse_fanout_n #(
    .N_OUT(4), .DELAY(5), .BEGIN_CYCLES(8), .MIN_SEP(2), .CNT_W(2)
  ) dut0 (
    .clk(clk), .rst(rst), .in(in_s), .out_en(out_en0), .viol_clr(viol_clr),
    .out(out0), .pulse_count(cnt0), .viol(viol0)
  );

  pulse_fanout_n #(
    .N_OUT(1), .DELAY(1), .BEGIN_CYCLES(1), .MIN_SEP(1), .CNT_W(8)
  ) dut1 (
    .clk(clk), .rst(rst), .in(in_s), .out_en(out_en1), .viol_clr(viol_clr),
    .out(out1), .pulse_count(cnt1), .viol(viol1)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Timeline model: every pulse is judged by its edge index since reset and its
  // distance to the previous accepted pulse; accepted pulses get an emit time.
  int p_delay[2] = '{5, 1};
  int p_begin[2] = '{8, 1};
  int p_sep[2]   = '{2, 1};
  int p_cntw[2]  = '{2, 8};

  int         m_k[2];
  int         m_last[2];
  bit         m_armed[2];
  bit         m_prev[2];
  bit         m_viol[2];
  int         m_cnt[2];
  logic [3:0] m_out[2];
  int         q0[$];
  int         q1[$];

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_k[d] = 0; m_last[d] = 0; m_armed[d] = 0; m_prev[d] = 0;
      m_viol[d] = 0; m_cnt[d] = 0; m_out[d] = '0;
    end
    q0.delete();
    q1.delete();
  endtask

  task automatic model_step(input int d, input logic [3:0] en);
    bit pulse;
    bit drop;
    bit emit;
    pulse = (in_s != m_prev[d]);
    m_prev[d] = in_s;
    drop = 0;
    emit = 0;
    if (m_k[d] >= p_begin[d] && pulse) begin
      if (!m_armed[d] || (m_k[d] - m_last[d]) >= p_sep[d]) begin
        if (d == 0) q0.push_back(m_k[d] + p_delay[d]);
        else        q1.push_back(m_k[d] + p_delay[d]);
        m_armed[d] = 1;
        m_last[d]  = m_k[d];
      end else begin
        drop = 1;
      end
    end
    if (drop) m_viol[d] = 1;
    else if (viol_clr) m_viol[d] = 0;
    if (d == 0) begin
      if (q0.size() > 0 && q0[0] == m_k[d]) begin void'(q0.pop_front()); emit = 1; end
    end else begin
      if (q1.size() > 0 && q1[0] == m_k[d]) begin void'(q1.pop_front()); emit = 1; end
    end
    if (emit) begin
      m_out[d] = m_out[d] ^ en;
      m_cnt[d] = (m_cnt[d] + 1) % (1 << p_cntw[d]);
    end
    m_k[d]++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(0, out_en0);
    model_step(1, {3'b000, out_en1});
    @(negedge clk);
    check("out0",  32'(out0),  32'(m_out[0]));
    check("cnt0",  32'(cnt0),  32'(m_cnt[0]));
    check("viol0", 32'(viol0), 32'(m_viol[0]));
    check("out1",  32'(out1),  32'(m_out[1][0]));
    check("cnt1",  32'(cnt1),  32'(m_cnt[1]));
    check("viol1", 32'(viol1), 32'(m_viol[1]));
  endtask

  task automatic run_to(input int e);
    while (m_k[0] < e) tick();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    #1;
    check("rst_out0",  32'(out0),  32'h0);
    check("rst_cnt0",  32'(cnt0),  32'h0);
    check("rst_viol0", 32'(viol0), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  int seq[5] = '{1, 2, 3, 0, 1};

  initial begin
    model_reset();

    // 1: pulse inside blanking is ignored
    do_reset();
    run_to(3);
    in_s = ~in_s;
    run_to(13);
    check("t1_out",  32'(out0),  32'h0);
    check("t1_cnt",  32'(cnt0),  32'h0);
    check("t1_viol", 32'(viol0), 32'h0);

    // 2: latency and masked fan-out (in=1 at release is blanked)
    do_reset();
    run_to(20);
    in_s = ~in_s;
    run_to(25);
    check("t2_pre_out", 32'(out0), 32'h0);
    tick();
    check("t2_out", 32'(out0), 32'hb);
    check("t2_cnt", 32'(cnt0), 32'h1);

    // 3: separation violation, then clear
    do_reset();
    run_to(20);
    in_s = ~in_s;
    tick();
    in_s = ~in_s;
    run_to(30);
    check("t3_viol", 32'(viol0), 32'h1);
    check("t3_cnt",  32'(cnt0),  32'h1);
    check("t3_b2b_cnt", 32'(cnt1), 32'h2);
    viol_clr = 1'b1;
    tick();
    viol_clr = 1'b0;
    check("t3_clr", 32'(viol0), 32'h0);

    // 4: clear and new violation at the same edge: set wins
    run_to(40);
    in_s = ~in_s;
    tick();
    in_s = ~in_s;
    viol_clr = 1'b1;
    tick();
    viol_clr = 1'b0;
    check("t4_viol", 32'(viol0), 32'h1);

    // 5: counter wrap with CNT_W=2
    do_reset();
    for (int e = 20; e <= 38; e++) begin
      run_to(e);
      if (e <= 32 && (e - 20) % 3 == 0) in_s = ~in_s;
      tick();
      if (e >= 25 && (e - 25) % 3 == 0) check("t5_cnt", 32'(cnt0), 32'(seq[(e - 25) / 3]));
    end

    // 6: reset mid-flight discards the pulse and restarts blanking
    do_reset();
    run_to(20);
    in_s = ~in_s;
    tick();
    tick();
    do_reset();
    run_to(6);
    check("t6_no_emit", 32'(out0), 32'h0);
    check("t6_cnt0",    32'(cnt0), 32'h0);
    run_to(3);
    in_s = ~in_s;
    run_to(8);
    in_s = ~in_s;
    run_to(13);
    check("t6_blank_cnt", 32'(cnt0), 32'h0);
    tick();
    check("t6_emit_cnt", 32'(cnt0), 32'h1);
    check("t6_emit_out", 32'(out0), 32'hb);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) do_reset();
      if ($urandom_range(0, 2) == 0) in_s = ~in_s;
      out_en0  = 4'($urandom);
      out_en1  = 1'($urandom);
      viol_clr = ($urandom_range(0, 7) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
